// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Asynchronous serial receiver for the ADC command/config path.
// Frame: start bit, DATA_BITS data bits (LSB first), optional parity bit,
// one stop bit. Bit timing comes from a runtime Divider that is latched at
// start detection.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits; mismatch flags Parity_Err
//   undefined -> no parity bit, Parity_Err is always 0, PARITY_ODD unused
//
// Ports
//   Sample_Clk   in   clock, all logic on rising edge
//   Reset_N      in   synchronous active-low reset
//   Divider      in   Sample_Clk cycles per bit (values below 4 act as 4)
//   Serin        in   asynchronous serial line, idle high
//   Data_Ready   in   consumer accepts Data_Out when high with Data_Valid
//   Data_Out     out  received word
//   Data_Valid   out  Data_Out holds an unconsumed word
//   Parity_Err   out  parity mismatch on the word in Data_Out
//   Frame_Err    out  1-cycle pulse, stop bit sampled low (word discarded)
//   Overrun_Err  out  1-cycle pulse, completed word dropped (consumer stalled)
//   Busy         out  receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Sample_Clk,
  input  logic                 Reset_N,
  input  logic [DIV_WIDTH-1:0] Divider,
  input  logic                 Serin,
  input  logic                 Data_Ready,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Overrun_Err,
  output logic                 Busy
);

  localparam int                   IDX_W    = (DATA_BITS > 8) ? 4 : 3;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Expected parity bit for a word: even parity when odd == 0.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word,
                                       input logic odd);
    return (^word) ^ odd;
  endfunction

  state_t                 state_q,   state_d;
  logic [DIV_WIDTH-1:0]   cnt_q,     cnt_d;
  logic [DIV_WIDTH-1:0]   div_q,     div_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   sync1_q,   sync1_d;
  logic                   s_q,       s_d;
  logic                   s_prev_q,  s_prev_d;
  logic                   par_bad_q, par_bad_d;
  logic                   pend_q,    pend_d;
  logic [DATA_BITS-1:0]   data_q,    data_d;
  logic                   valid_q,   valid_d;
  logic                   perr_q,    perr_d;
  logic                   ferr_q,    ferr_d;
  logic                   ovr_q,     ovr_d;
  logic                   busy_q,    busy_d;

`ifndef UART_RX_PARITY_EN
  logic unused_parity_cfg;
  assign unused_parity_cfg = 1'(PARITY_ODD);
`endif

  // Next-state logic: synchroniser, bit-timing FSM and output handshake.
  always_comb begin
    sync1_d   = Serin;
    s_d       = sync1_q;
    s_prev_d  = s_q;
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_WIDTH'(1);
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    pend_d    = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = {DIV_WIDTH{1'b0}};
        bit_idx_d = {IDX_W{1'b0}};
        if (s_prev_q && !s_q) begin
          state_d = ST_START;
          div_d   = (Divider < MIN_DIV) ? MIN_DIV : Divider;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // Mid start bit: a high line here means the low pulse was a glitch.
        if (cnt_q == (div_q >> 1)) begin
          cnt_d   = {DIV_WIDTH{1'b0}};
          state_d = s_q ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == div_q - DIV_WIDTH'(1)) begin
          cnt_d     = {DIV_WIDTH{1'b0}};
          shift_d   = {s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == div_q - DIV_WIDTH'(1)) begin
          cnt_d     = {DIV_WIDTH{1'b0}};
          par_bad_d = (s_q != calc_parity(shift_q, 1'(PARITY_ODD)));
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // Leave at mid stop bit so a following start edge is not missed.
        if (cnt_q == div_q - DIV_WIDTH'(1)) begin
          cnt_d   = {DIV_WIDTH{1'b0}};
          state_d = ST_IDLE;
          if (s_q) begin
            pend_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {DIV_WIDTH{1'b0}};
      end
    endcase

    // shift_q is untouched for at least a bit time after the stop sample,
    // so the pending word is read straight from it.
    if (pend_q) begin
      if (valid_q && !Data_Ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        perr_d  = par_bad_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && Data_Ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Sample_Clk) begin
    if (!Reset_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {DIV_WIDTH{1'b0}};
      div_q     <= {DIV_WIDTH{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      sync1_q   <= 1'b1;
      s_q       <= 1'b1;
      s_prev_q  <= 1'b1;
      par_bad_q <= 1'b0;
      pend_q    <= 1'b0;
      data_q    <= {DATA_BITS{1'b0}};
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      s_prev_q  <= s_prev_d;
      par_bad_q <= par_bad_d;
      pend_q    <= pend_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign Data_Out    = data_q;
  assign Data_Valid  = valid_q;
  assign Parity_Err  = perr_q;
  assign Frame_Err   = ferr_q;
  assign Overrun_Err = ovr_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param (8 data bits). Frames are driven on the
// falling clock edge, outputs are sampled on the falling edge, and error
// pulses are counted cycle by cycle so their width can be checked.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divider;
  logic        serin;
  logic        ready;
  logic [7:0]  data_out;
  logic        valid;
  logic        perr;
  logic        ferr;
  logic        ovr;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;
  int ferr_cyc   = 0;
  int ovr_cyc    = 0;
  int both_cyc   = 0;

  uart_rx_param #(
    .DATA_BITS (8),
    .DIV_WIDTH (16),
    .PARITY_ODD(0)
  ) dut (
    .Sample_Clk (clk),
    .Reset_N    (rst_n),
    .Divider    (divider),
    .Serin      (serin),
    .Data_Ready (ready),
    .Data_Out   (data_out),
    .Data_Valid (valid),
    .Parity_Err (perr),
    .Frame_Err  (ferr),
    .Overrun_Err(ovr),
    .Busy       (busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of the error pulses.
  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cyc++;
    if (ovr === 1'b1) ovr_cyc++;
    if (ferr === 1'b1 && ovr === 1'b1) both_cyc++;
  end

  task automatic drive_bit(input logic b, input int cyc);
    serin = b;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_b,
                            input logic stop_b, input int cyc);
    drive_bit(1'b0, cyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cyc);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b, cyc);
`else
    if (par_b === 1'bx) serin = 1'b1;
`endif
    drive_bit(stop_b, cyc);
    serin = 1'b1;
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; serin = 1'b1; ready = 1'b0; divider = 16'd16;
    repeat (3) @(negedge clk);
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_out); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if ({perr, ferr, ovr} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {perr, ferr, ovr}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int f0, o0;
    f0 = ferr_cyc; o0 = ovr_cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    vectors++; if (data_out !== 8'hA5) begin miscompares++; $display("FAIL basic_data: got %h want a5", data_out); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", valid); end
    vectors++; if (perr !== 1'b0) begin miscompares++; $display("FAIL basic_perr: got %b want 0", perr); end
    vectors++; if ((ferr_cyc - f0) !== 0 || (ovr_cyc - o0) !== 0) begin miscompares++; $display("FAIL basic_errs: got frame %0d overrun %0d want 0 0", ferr_cyc - f0, ovr_cyc - o0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %b want 0", busy); end
    consume();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_consume: got %b want 0", valid); end
  endtask

  task automatic test_glitch();
    int f0, o0;
    f0 = ferr_cyc; o0 = ovr_cyc;
    serin = 1'b0;
    repeat (3) @(negedge clk);
    serin = 1'b1;
    repeat (24) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy: got %b want 0", busy); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b want 0", valid); end
    vectors++; if ((ferr_cyc - f0) !== 0 || (ovr_cyc - o0) !== 0) begin miscompares++; $display("FAIL glitch_flags: got frame %0d overrun %0d want 0 0", ferr_cyc - f0, ovr_cyc - o0); end
  endtask

  task automatic test_frame_err();
    int f0, o0;
    f0 = ferr_cyc; o0 = ovr_cyc;
    send_frame(8'h3C, 1'b0, 1'b0, 16);
    repeat (6) @(negedge clk);
    vectors++; if ((ferr_cyc - f0) !== 1) begin miscompares++; $display("FAIL frame_pulse: got %0d cycles want 1", ferr_cyc - f0); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL frame_valid: got %b want 0", valid); end
    vectors++; if ((ovr_cyc - o0) !== 0) begin miscompares++; $display("FAIL frame_ovr: got %0d want 0", ovr_cyc - o0); end
  endtask

  task automatic test_back_to_back();
    int f0, o0;
    f0 = ferr_cyc; o0 = ovr_cyc;
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 16);
    vectors++; if (valid !== 1'b1 || data_out !== 8'h11) begin miscompares++; $display("FAIL b2b_first: got valid %b data %h want 1 11", valid, data_out); end
    vectors++; if ((ovr_cyc - o0) !== 0) begin miscompares++; $display("FAIL b2b_early_ovr: got %0d want 0", ovr_cyc - o0); end
    send_frame(8'h22, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    vectors++; if (data_out !== 8'h11) begin miscompares++; $display("FAIL b2b_held: got %h want 11", data_out); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", valid); end
    vectors++; if ((ovr_cyc - o0) !== 1) begin miscompares++; $display("FAIL b2b_ovr_pulse: got %0d cycles want 1", ovr_cyc - o0); end
    vectors++; if ((ferr_cyc - f0) !== 0) begin miscompares++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cyc - f0); end
    consume();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL b2b_consume: got %b want 0", valid); end
  endtask

  task automatic test_min_divider();
    divider = 16'd2;
    send_frame(8'h96, 1'b0, 1'b1, 4);
    repeat (6) @(negedge clk);
    vectors++; if (valid !== 1'b1 || data_out !== 8'h96) begin miscompares++; $display("FAIL mindiv_data: got valid %b data %h want 1 96", valid, data_out); end
    consume();
    divider = 16'd16;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    w = 8'h5A;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(w[i], 16);
    drive_bit(w[4], 8);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; serin = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL midrst_after: got busy %b valid %b want 0 0", busy, valid); end
    repeat (40) @(negedge clk);
    vectors++; if (busy !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL midrst_quiet: got busy %b valid %b want 0 0", busy, valid); end
    send_frame(8'h5A, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    vectors++; if (valid !== 1'b1 || data_out !== 8'h5A) begin miscompares++; $display("FAIL midrst_next: got valid %b data %h want 1 5a", valid, data_out); end
    consume();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h03, 1'b1, 1'b1, 16);
    repeat (4) @(negedge clk);
    vectors++; if (valid !== 1'b1 || data_out !== 8'h03) begin miscompares++; $display("FAIL par_bad_data: got valid %b data %h want 1 03", valid, data_out); end
    vectors++; if (perr !== 1'b1) begin miscompares++; $display("FAIL par_bad_flag: got %b want 1", perr); end
    consume();
    send_frame(8'h03, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    vectors++; if (valid !== 1'b1 || data_out !== 8'h03) begin miscompares++; $display("FAIL par_good_data: got valid %b data %h want 1 03", valid, data_out); end
    vectors++; if (perr !== 1'b0) begin miscompares++; $display("FAIL par_good_flag: got %b want 0", perr); end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_min_divider();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    vectors++; if (both_cyc !== 0) begin miscompares++; $display("FAIL err_exclusive: got %0d overlapping cycles want 0", both_cyc); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
